// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration frame loader.
//   state_t : loader FSM states
//   END_CMD : header byte that locks all configuration
//   IDX_W   : width of the target index field in a header byte
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_DISCARD = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_LOCKED  = 3'd4
  } state_t;

  localparam logic [7:0] END_CMD = 8'hFF;
  localparam int         IDX_W   = 7;

endpackage

// File: rtl/cfg_byte_assembler.sv
// Collects payload bytes of one frame into a shadow word, LSB byte first.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_take        : a payload byte is consumed this cycle (counts the byte)
//   i_store       : write the consumed byte into the shadow word
//   i_byte        : payload byte
//   o_shadow      : assembled word
//   o_last_byte   : the next consumed byte is the last one of the frame
module cfg_byte_assembler #(
  parameter int CFG_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_take,
  input  logic             i_store,
  input  logic [7:0]       i_byte,
  output logic [CFG_W-1:0] o_shadow,
  output logic             o_last_byte
);

  localparam int BYTES = CFG_W / 8;
  localparam int CNT_W = $clog2(BYTES) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_shadow [BYTES];

  assign o_last_byte = (r_cnt == CNT_W'(BYTES - 1));

  // Counter wraps to 0 after the last byte, so every frame starts at byte 0
  // without an explicit clear from the controller.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_take) begin
      r_cnt <= o_last_byte ? '0 : r_cnt + 1'b1;
    end
  end

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_shadow[gi] <= '0;
      end else if (i_take && i_store && (r_cnt == CNT_W'(gi))) begin
        r_shadow[gi] <= i_byte;
      end
    end
    assign o_shadow[gi*8 +: 8] = r_shadow[gi];
  end

endmodule

// File: rtl/cfg_frame_loader.sv
// Consumes a byte stream of addressed config frames and drives the config
// word of each child cell slot. A slot is updated atomically one cycle after
// its last payload byte; an END header locks all configuration until reset.
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_din          : stream byte
//   i_din_valid    : i_din valid
//   o_din_ready    : loader accepts i_din this cycle
//   o_cfg          : slot t at [t*CFG_W +: CFG_W]
//   o_cfg_locked   : END command received
//   o_busy         : frame in progress
//   o_err          : sticky, a header addressed a bad/reserved slot
module cfg_frame_loader
  import cfg_loader_pkg::*;
#(
  parameter int N_TARGETS = 5,
  parameter int CFG_W     = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [7:0]                 i_din,
  input  logic                       i_din_valid,
  output logic                       o_din_ready,
  output logic [N_TARGETS*CFG_W-1:0] o_cfg,
  output logic                       o_cfg_locked,
  output logic                       o_busy,
  output logic                       o_err
);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_tgt;
  logic             r_err;
  logic [CFG_W-1:0] r_slot [N_TARGETS];

  logic             w_take;
  logic             w_hdr_ok;
  logic             w_asm_take;
  logic             w_asm_store;
  logic             w_last_byte;
  logic [CFG_W-1:0] w_shadow;

  assign o_din_ready  = (r_state != ST_COMMIT) && (r_state != ST_LOCKED);
  assign o_busy       = (r_state == ST_PAYLOAD) || (r_state == ST_DISCARD) ||
                        (r_state == ST_COMMIT);
  assign o_cfg_locked = (r_state == ST_LOCKED);
  assign o_err        = r_err;

  assign w_take = i_din_valid && o_din_ready;
  // Bit 7 set is reserved (0xFF is handled before this check), so only
  // plain indices below N_TARGETS address a real slot.
  assign w_hdr_ok = !i_din[7] && ({1'b0, i_din[IDX_W-1:0]} < 8'(N_TARGETS));

  always_comb begin
    w_state_next = r_state;
    w_asm_take   = 1'b0;
    w_asm_store  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_take) begin
          if (i_din == END_CMD) w_state_next = ST_LOCKED;
          else if (w_hdr_ok)    w_state_next = ST_PAYLOAD;
          else                  w_state_next = ST_DISCARD;
        end
      end
      ST_PAYLOAD: begin
        if (w_take) begin
          w_asm_take  = 1'b1;
          w_asm_store = 1'b1;
          if (w_last_byte) w_state_next = ST_COMMIT;
        end
      end
      ST_DISCARD: begin
        if (w_take) begin
          w_asm_take = 1'b1;
          if (w_last_byte) w_state_next = ST_IDLE;
        end
      end
      ST_COMMIT: w_state_next = ST_IDLE;
      ST_LOCKED: w_state_next = ST_LOCKED;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_tgt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ST_IDLE) && w_take) begin
        if (w_hdr_ok) r_tgt <= i_din[IDX_W-1:0];
        else if (i_din != END_CMD) r_err <= 1'b1;
      end
    end
  end

  cfg_byte_assembler #(.CFG_W(CFG_W)) u_asm (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_take      (w_asm_take),
    .i_store     (w_asm_store),
    .i_byte      (i_din),
    .o_shadow    (w_shadow),
    .o_last_byte (w_last_byte)
  );

  // Slots only change in COMMIT, when the shadow word is complete.
  for (genvar gi = 0; gi < N_TARGETS; gi++) begin : g_slot
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_slot[gi] <= '0;
      end else if ((r_state == ST_COMMIT) && (r_tgt == IDX_W'(gi))) begin
        r_slot[gi] <= w_shadow;
      end
    end
    assign o_cfg[gi*CFG_W +: CFG_W] = r_slot[gi];
  end

endmodule
